// File: rtl/warp_scheduler_pkg.sv
// Shared enums for the warp scheduler: core pipeline state, per-warp status
// and scheduler FSM states.
package warp_scheduler_pkg;

   // Core pipeline state of the running warp.
   typedef enum logic [2:0] {
      CORE_IDLE    = 3'd0,
      CORE_FETCH   = 3'd1,
      CORE_DECODE  = 3'd2,
      CORE_REQUEST = 3'd3,
      CORE_WAIT    = 3'd4,
      CORE_EXECUTE = 3'd5,
      CORE_UPDATE  = 3'd6,
      CORE_DONE    = 3'd7
   } corestate_t;

   // Per-warp scheduling status.
   typedef enum logic [1:0] {
      W_INACTIVE = 2'd0,
      W_READY    = 2'd1,
      W_WAITING  = 2'd2,
      W_FINISHED = 2'd3
   } warpstat_t;

   // Scheduler FSM states.
   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_LAUNCH   = 3'd1,
      S_RUN      = 3'd2,
      S_SWITCH   = 3'd3,
      S_ALL_WAIT = 3'd4,
      S_DONE     = 3'd5
   } wsched_state_t;

endpackage

// File: rtl/warp_scheduler_rr_picker.sv
// Round-robin picker: returns the first ready warp after cur_i, wrapping,
// with cur_i itself considered last. Purely combinational.
module warp_scheduler_rr_picker #(
   parameter int N = 2,
   parameter int W = 1
) (
   input  logic [N-1:0] ready_i,
   input  logic [W-1:0] cur_i,
   output logic [W-1:0] next_o,
   output logic         found_o
);

   // Scan cur+1 .. cur+N (mod N); the first ready hit wins.
   always_comb begin
      int  idx;
      logic hit;
      next_o  = cur_i;
      found_o = 1'b0;
      idx     = 0;
      hit     = 1'b0;
      for (int off = 1; off <= N; off++) begin
         idx     = int'(cur_i) + off;
         idx     = (idx >= N) ? (idx - N) : idx;
         hit     = ready_i[idx] && !found_o;
         next_o  = hit ? W'(idx) : next_o;
         found_o = found_o || ready_i[idx];
      end
   end

endmodule

// File: rtl/warp_scheduler.sv
// Per-core warp scheduler. Launches warps, tracks their status and hands
// the shared pipeline to the next ready warp (round-robin) whenever the
// running warp stalls on memory or finishes.
// Optional time-slice preemption is built when WARP_SCHED_TIMESLICE_EN is
// defined; the default build has no preemption.
module warp_scheduler
   import warp_scheduler_pkg::*;
#(
   parameter int NUM_WARPS_PER_CORE = 2,
   parameter int WARP_ID_BITS       = $clog2(NUM_WARPS_PER_CORE),
   parameter int QUANTUM            = 16
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          start,
   input  logic [NUM_WARPS_PER_CORE-1:0] warp_enable,
   input  corestate_t                    core_state,
   input  logic                          warp_stall,
   input  logic                          warp_done,
   input  logic [NUM_WARPS_PER_CORE-1:0] mem_ready,
   output logic [WARP_ID_BITS-1:0]       warp_select,
   output logic                          warp_valid,
   output logic [NUM_WARPS_PER_CORE-1:0] warp_reset,
   output logic                          switch_pulse,
   output logic                          busy,
   output logic                          done
);

   localparam int N = NUM_WARPS_PER_CORE;
   localparam int W = WARP_ID_BITS;

   wsched_state_t state_q, state_d;
   warpstat_t     status_q [N];
   warpstat_t     status_d [N];
   logic [N-1:0]  enable_q, enable_d;
   logic [W-1:0]  sel_q, sel_d;
   logic [W-1:0]  lowest_s;

   logic [N-1:0]  ready_mask_s;
   logic [W-1:0]  pick_next_s;
   logic          pick_found_s;
   logic          launch_s;
   logic          event_s;
   logic          preempt_s;
   logic          live_s;

   logic          warp_valid_q, warp_valid_d;
   logic [N-1:0]  warp_reset_q, warp_reset_d;
   logic          switch_pulse_q, switch_pulse_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;

   assign launch_s = start && ((state_q == S_IDLE) || (state_q == S_DONE));
   // A stall that coincides with its own memory completion is no event.
   assign event_s  = (state_q == S_RUN) &&
                     (warp_done || (warp_stall && !mem_ready[sel_q]));

`ifdef WARP_SCHED_TIMESLICE_EN
   localparam int CNT_BITS = $clog2(QUANTUM) + 1;
   logic [CNT_BITS-1:0] run_cnt_q, run_cnt_d;

   // Run counter: zero outside S_RUN, counts S_RUN cycles, saturates.
   always_comb begin
      if (state_q != S_RUN) begin
         run_cnt_d = {CNT_BITS{1'b0}};
      end else if (run_cnt_q < CNT_BITS'(QUANTUM - 1)) begin
         run_cnt_d = run_cnt_q + CNT_BITS'(1);
      end else begin
         run_cnt_d = run_cnt_q;
      end
   end

   // Run counter register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         run_cnt_q <= {CNT_BITS{1'b0}};
      end else begin
         run_cnt_q <= run_cnt_d;
      end
   end

   assign preempt_s = (state_q == S_RUN) && !warp_stall && !warp_done &&
                      (run_cnt_q >= CNT_BITS'(QUANTUM - 1)) &&
                      (core_state == CORE_FETCH) &&
                      pick_found_s && (pick_next_s != sel_q);
`else
   logic [2:0]  core_state_unused_s;
   logic [31:0] quantum_unused_s;
   assign core_state_unused_s = core_state;
   assign quantum_unused_s    = 32'(QUANTUM);
   assign preempt_s           = 1'b0;
`endif

   // Lowest enabled warp index, used as the first warp after launch.
   always_comb begin
      lowest_s = {W{1'b0}};
      for (int i = N - 1; i >= 0; i--) begin
         lowest_s = warp_enable[i] ? W'(i) : lowest_s;
      end
   end

   // Per-warp status next-state: memory wakeups, launch, run-time events.
   always_comb begin
      for (int i = 0; i < N; i++) begin
         if ((status_q[i] == W_WAITING) && mem_ready[i]) begin
            status_d[i] = W_READY;
         end else begin
            status_d[i] = status_q[i];
         end
      end
      if (launch_s) begin
         for (int i = 0; i < N; i++) begin
            status_d[i] = warp_enable[i] ? W_READY : W_INACTIVE;
         end
      end else if (state_q == S_RUN) begin
         if (warp_done) begin
            status_d[sel_q] = W_FINISHED;
         end else if (warp_stall && !mem_ready[sel_q]) begin
            status_d[sel_q] = W_WAITING;
         end else begin
            status_d[sel_q] = status_d[sel_q];
         end
      end else begin
         status_d[0] = status_d[0];
      end
   end

   // Ready mask and liveness derived from the updated status.
   always_comb begin
      live_s = 1'b0;
      for (int i = 0; i < N; i++) begin
         ready_mask_s[i] = (status_d[i] == W_READY);
         live_s = live_s || (status_d[i] == W_READY) || (status_d[i] == W_WAITING);
      end
   end

   warp_scheduler_rr_picker #(
      .N (N),
      .W (W)
   ) u_picker (
      .ready_i (ready_mask_s),
      .cur_i   (sel_q),
      .next_o  (pick_next_s),
      .found_o (pick_found_s)
   );

   // FSM state register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next-state logic, including warp selection and enable capture.
   always_comb begin
      state_d  = state_q;
      sel_d    = sel_q;
      enable_d = enable_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               enable_d = warp_enable;
               if (warp_enable == {N{1'b0}}) begin
                  state_d = S_DONE;
               end else begin
                  state_d = S_LAUNCH;
                  sel_d   = lowest_s;
               end
            end else begin
               state_d = state_q;
            end
         end
         S_LAUNCH: state_d = S_RUN;
         S_RUN: begin
            if (event_s || preempt_s) begin
               if (pick_found_s) begin
                  sel_d   = pick_next_s;
                  state_d = S_SWITCH;
               end else if (!live_s) begin
                  state_d = S_DONE;
               end else begin
                  state_d = S_ALL_WAIT;
               end
            end else begin
               state_d = S_RUN;
            end
         end
         S_SWITCH: state_d = S_RUN;
         S_ALL_WAIT: begin
            if (pick_found_s) begin
               sel_d   = pick_next_s;
               state_d = S_SWITCH;
            end else begin
               state_d = S_ALL_WAIT;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // FSM output logic: outputs are registered against the next state.
   always_comb begin
      warp_valid_d   = (state_d == S_RUN);
      switch_pulse_d = (state_d == S_SWITCH);
      done_d         = (state_d == S_DONE);
      busy_d         = (state_d == S_LAUNCH) || (state_d == S_RUN) ||
                       (state_d == S_SWITCH) || (state_d == S_ALL_WAIT);
      if (state_d == S_LAUNCH) begin
         warp_reset_d = enable_d;
      end else begin
         warp_reset_d = {N{1'b0}};
      end
   end

   // Datapath and output registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < N; i++) begin
            status_q[i] <= W_INACTIVE;
         end
         enable_q       <= {N{1'b0}};
         sel_q          <= {W{1'b0}};
         warp_valid_q   <= 1'b0;
         warp_reset_q   <= {N{1'b0}};
         switch_pulse_q <= 1'b0;
         busy_q         <= 1'b0;
         done_q         <= 1'b0;
      end else begin
         for (int i = 0; i < N; i++) begin
            status_q[i] <= status_d[i];
         end
         enable_q       <= enable_d;
         sel_q          <= sel_d;
         warp_valid_q   <= warp_valid_d;
         warp_reset_q   <= warp_reset_d;
         switch_pulse_q <= switch_pulse_d;
         busy_q         <= busy_d;
         done_q         <= done_d;
      end
   end

   assign warp_select  = sel_q;
   assign warp_valid   = warp_valid_q;
   assign warp_reset   = warp_reset_q;
   assign switch_pulse = switch_pulse_q;
   assign busy         = busy_q;
   assign done         = done_q;

endmodule

// File: doc/warp_scheduler.md
Name: warp_scheduler

Overview:
- Per-core warp scheduler. Chooses which warp owns the shared core pipeline by driving `warp_select` into the warp controller.
- Launches warps at block start and tracks per-warp status: inactive, ready, waiting on memory, finished.
- Swaps out a warp that stalls on memory or finishes, picking the next ready warp by round-robin.
- Signals block completion when all enabled warps have finished.

Parameters:
- NUM_WARPS_PER_CORE, 2, warps sharing one core pipeline; any value ≥2.
- WARP_ID_BITS, $clog2(NUM_WARPS_PER_CORE), width of the warp index.
- QUANTUM, 16, time-slice length in cycles; used only with WARP_SCHED_TIMESLICE_EN.

Ports:
- clk  in  1  clock, posedge; all outputs stable across the negedge used by the warp controller.
- reset  in  1  asynchronous, active-high.
- start  in  1  launch pulse; ignored unless in S_IDLE or S_DONE.
- warp_enable  in  NUM_WARPS_PER_CORE  warps with work; sampled on the start cycle.
- core_state  in  3  corestate_t of the running warp.
- warp_stall  in  1  running warp issued a memory access and must wait.
- warp_done  in  1  running warp executed RET.
- mem_ready  in  NUM_WARPS_PER_CORE  per-warp memory completion pulse.
- warp_select  out  WARP_ID_BITS  index of the warp owning the pipeline.
- warp_valid  out  1  warp_select owns the pipeline this cycle.
- warp_reset  out  NUM_WARPS_PER_CORE  one-cycle reset pulse per launched warp.
- switch_pulse  out  1  one cycle, on entry to S_SWITCH.
- busy  out  1  high in S_LAUNCH, S_RUN, S_SWITCH, S_ALL_WAIT.
- done  out  1  high in S_DONE.

Behaviour:
- Reset values: state S_IDLE; all warp status W_INACTIVE; all outputs 0.
- Per-warp status (2 bits): W_INACTIVE, W_READY, W_WAITING, W_FINISHED.
- Round-robin "next": the first W_READY warp at index cur+1, cur+2, … wrapping. cur itself is considered last.
- S_IDLE / S_DONE with start:
  - If warp_enable == 0: go to S_DONE; no warp_reset pulse.
  - Otherwise: enabled warps become W_READY, all others W_INACTIVE; warp_select = lowest enabled index; go to S_LAUNCH.
- S_LAUNCH: warp_reset = warp_enable for exactly one cycle; then S_RUN.
- S_RUN: warp_valid = 1. Evaluated each cycle for cur = warp_select:
  - warp_done → cur becomes W_FINISHED. warp_done has priority over warp_stall.
  - warp_stall (no warp_done) → cur becomes W_WAITING. Exception: if mem_ready[cur] is high in the same cycle, cur stays W_READY and there is no switch.
  - On either event:
    - a ready warp exists → latch warp_select = next, go to S_SWITCH;
    - all enabled warps finished → S_DONE;
    - otherwise → S_ALL_WAIT.
- mem_ready[i]: any W_WAITING warp becomes W_READY in the same cycle, in every state. mem_ready on a non-waiting warp is ignored.
- S_SWITCH: warp_valid = 0 for one bubble cycle; then S_RUN.
  - Latency: stall at cycle N → new warp_select visible at N+1, warp_valid high at N+2.
- S_ALL_WAIT: warp_valid = 0. When any warp becomes W_READY, latch warp_select = next, go to S_SWITCH. If several become ready at once, round-robin order from cur decides.
- S_DONE: done = 1 and holds until the next start.
- Asynchronous reset mid-operation: immediate return to S_IDLE; all status cleared.
- warp_stall and warp_done are ignored outside S_RUN.

Optional Feature:
- Macro: WARP_SCHED_TIMESLICE_EN.
- With the macro:
  - A run counter clears on entry to S_RUN and counts each S_RUN cycle.
  - Preemption triggers when count ≥ QUANTUM-1, core_state == CORE_FETCH, another W_READY warp exists, and there is no stall or done.
  - On preemption cur stays W_READY and the block switches to next.
  - With no other ready warp, the counter saturates and the current warp continues.
- Without the macro: no counter; a warp runs until it stalls or finishes.

Decomposition:
- corestate_t and CORE_* values come from the existing shared enums package.
- Add to that package:
  - warpstat_t (W_INACTIVE, W_READY, W_WAITING, W_FINISHED);
  - wsched_state_t (S_IDLE, S_LAUNCH, S_RUN, S_SWITCH, S_ALL_WAIT, S_DONE).
- One sub-module: rr_picker. Combinational: takes a ready mask and the current index, returns next index and found flag. It is reused in S_RUN and S_ALL_WAIT.

Test Plan:
- Launch: start with warp_enable=2'b11 → warp_reset=2'b11 for 1 cycle, then warp_select=0 and warp_valid=1.
- Stall switch: warp 0 warp_stall at cycle N → switch_pulse, warp_select=1 at N+1, warp_valid=1 at N+2; mem_ready[0] later → warp 0 becomes W_READY.
- All waiting: both warps stall, no mem_ready → S_ALL_WAIT with warp_valid=0; mem_ready[1] → warp_select=1 two cycles later.
- Completion: both warps assert warp_done in turn → done=1 and busy=0; new start relaunches; start with warp_enable=0 → done with no warp_reset pulse.
- Corners: stall with same-cycle mem_ready[cur] → no switch; asynchronous reset during S_SWITCH → all outputs 0 immediately.
- Timeslice (WARP_SCHED_TIMESLICE_EN, QUANTUM=4): both warps ready, no stalls → switch at the first CORE_FETCH after 4 run cycles; alternating 0,1,0.
